// File: rtl/maxq_pkg.sv
// maxq_pkg: shared constants and types for the find-max result queue.
//   MAXQ_DATA_W  : default result width (matches the find-max datapath)
//   SEQ_CNT_W    : width of the completed-sequence statistics counter
//   maxq_state_t : occupancy state of the result FIFO
package maxq_pkg;

    localparam int unsigned MAXQ_DATA_W = 8;
    localparam int unsigned SEQ_CNT_W   = 16;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } maxq_state_t;

endpackage

// File: rtl/maxq_storage.sv
// maxq_storage: DEPTH x DATA_W register array backing the result FIFO.
// Ports:
//   clk, rst : rising-edge clock, asynchronous active-high reset (clears all entries)
//   we       : write enable
//   waddr    : write address
//   wdata    : write data
//   raddr    : read address (combinational read)
//   rdata    : read data
module maxq_storage #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/max_result_queue.sv
// max_result_queue: captures maxValue on each done pulse from the find-max
// FSM-D and queues results in a small FIFO drained through valid/ready.
// Optional statistics are enabled by defining MAXQ_STATS_EN.
// Ports:
//   clk, rst  : rising-edge clock, asynchronous active-high reset
//   done_in   : one-cycle completion pulse; max_in sampled in that cycle
//   max_in    : result value to queue
//   out_valid : head entry available
//   out_ready : consumer accepts the head entry
//   out_data  : head entry (0 when empty)
//   count     : current occupancy (0..DEPTH)
//   full      : count == DEPTH
//   overflow  : sticky, set when a result is dropped while full
//   clr_ovf   : synchronous clear of overflow (a same-cycle drop wins)
//   seq_count : completed sequences, saturating (0 without MAXQ_STATS_EN)
//   peak_max  : largest max_in seen (0 without MAXQ_STATS_EN)
module max_result_queue
    import maxq_pkg::*;
#(
    parameter int unsigned DATA_W = MAXQ_DATA_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     done_in,
    input  logic [DATA_W-1:0]        max_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow,
    input  logic                     clr_ovf,
    output logic [SEQ_CNT_W-1:0]     seq_count,
    output logic [DATA_W-1:0]        peak_max
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

    maxq_state_t       state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [AW-1:0]     wptr_q, rptr_q;
    logic              ovf_q;
    logic              push, pop, drop;
    logic [DATA_W-1:0] head;

    assign out_valid = (state_q != EMPTY);
    assign full      = (state_q == FULL);
    assign pop       = out_valid & out_ready;
    // A pop in the same cycle frees the slot a full queue would otherwise lack.
    assign push      = done_in & (~full | pop);
    assign drop      = done_in & full & ~pop;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
        case (state_q)
            EMPTY: begin
                if (push) state_d = PARTIAL;
            end
            PARTIAL: begin
                if (push && !pop && count_q == CNT_LAST) begin
                    state_d = FULL;
                end else if (pop && !push && count_q == CNT_ONE) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop && !push) state_d = PARTIAL;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            // Pointers wrap naturally since DEPTH is a power of two.
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    maxq_storage #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_storage (
        .clk   (clk),
        .rst   (rst),
        .we    (push),
        .waddr (wptr_q),
        .wdata (max_in),
        .raddr (rptr_q),
        .rdata (head)
    );

    // Popped slots keep stale data, so the head is masked when empty.
    assign out_data = out_valid ? head : '0;
    assign count    = count_q;
    assign overflow = ovf_q;

`ifdef MAXQ_STATS_EN
    logic [SEQ_CNT_W-1:0] seq_q;
    logic [DATA_W-1:0]    peak_q;

    // Dropped results still count as completed sequences.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_q  <= '0;
            peak_q <= '0;
        end else if (done_in) begin
            if (seq_q != '1) seq_q <= seq_q + SEQ_CNT_W'(1);
            if (max_in > peak_q) peak_q <= max_in;
        end
    end

    assign seq_count = seq_q;
    assign peak_max  = peak_q;
`else
    assign seq_count = '0;
    assign peak_max  = '0;
`endif

endmodule
